// File: rtl/bram_dual_port_clr_if.sv
// ============================================================================
// Module   : bram_dual_port_clr_if
// Purpose  : Port A / port B / clear-control bundle for bram_dual_port_clr.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface bram_dual_port_clr_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 16
);
    logic                  en_a;
    logic                  we_a;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] din_a;
    logic [DATA_WIDTH-1:0] dout_a;
    logic                  en_b;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] dout_b;
    logic                  clr_start;
    logic                  clr_busy;
    logic                  clr_done;

    modport master (
        output en_a, we_a, addr_a, din_a, en_b, addr_b, clr_start,
        input  dout_a, dout_b, clr_busy, clr_done
    );

    modport slave (
        input  en_a, we_a, addr_a, din_a, en_b, addr_b, clr_start,
        output dout_a, dout_b, clr_busy, clr_done
    );
endinterface

`default_nettype wire

// File: rtl/bram_dual_port_clr.sv
// ============================================================================
// Module   : bram_dual_port_clr
// Purpose  : Dual-port block RAM (A read/write, B read-only) with zero-fill FSM.
//            Optional output register stage enabled by macro BRAM_OUTREG_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bram_dual_port_clr #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 16,
    parameter int RD_MODE    = 0
) (
    input  wire logic            clk,
    input  wire logic            reset,
    bram_dual_port_clr_if.slave  bus
);
    localparam int                    DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic                  clearing;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  a_load;
    logic [DATA_WIDTH-1:0] a_next;
    logic [DATA_WIDTH-1:0] a_q1;
    logic [DATA_WIDTH-1:0] b_q1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bus.clr_busy = 1'b0;
        bus.clr_done = 1'b0;
        case (state)
            IDLE: begin
                if (bus.clr_start) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                bus.clr_busy = 1'b1;
                if (cnt == LAST_ADDR) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.clr_done = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign clearing = (state == CLEAR);

    // Counter parks at the last address rather than wrapping; cleared outside CLEAR.
    always_ff @(posedge clk) begin
        if (reset || !clearing) begin
            cnt <= '0;
        end else if (cnt != LAST_ADDR) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Single physical write port shared by the fill engine and port A.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bus.addr_a;
        wr_data = bus.din_a;
        if (!reset) begin
            if (clearing) begin
                wr_en   = 1'b1;
                wr_addr = cnt;
                wr_data = '0;
            end else begin
                wr_en   = bus.en_a && bus.we_a;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A dropped write during the fill behaves as a plain read.
    always_comb begin
        a_load = bus.en_a;
        a_next = mem[bus.addr_a];
        if (bus.en_a && bus.we_a && !clearing) begin
            if (RD_MODE == 0) begin
                a_next = bus.din_a;
            end else if (RD_MODE == 2) begin
                a_load = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q1 <= '0;
            b_q1 <= '0;
        end else begin
            if (a_load) begin
                a_q1 <= a_next;
            end
            if (bus.en_b) begin
                b_q1 <= mem[bus.addr_b];
            end
        end
    end

`ifdef BRAM_OUTREG_EN
    logic                  a_vld;
    logic                  b_vld;
    logic [DATA_WIDTH-1:0] a_q2;
    logic [DATA_WIDTH-1:0] b_q2;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_vld <= 1'b0;
            b_vld <= 1'b0;
            a_q2  <= '0;
            b_q2  <= '0;
        end else begin
            a_vld <= a_load;
            b_vld <= bus.en_b;
            if (a_vld) begin
                a_q2 <= a_q1;
            end
            if (b_vld) begin
                b_q2 <= b_q1;
            end
        end
    end

    assign bus.dout_a = a_q2;
    assign bus.dout_b = b_q2;
`else
    assign bus.dout_a = a_q1;
    assign bus.dout_b = b_q1;
`endif

endmodule

`default_nettype wire
